// File: rtl/i2c_regfile_slave.sv
// i2c_regfile_slave: I2C target exposing NUM_REGS bytes with pointer, auto-increment, reads and busy NACK
module i2c_regfile_slave #(
    parameter logic [6:0] SLAVE_ADDR = 7'h55,
    parameter int         NUM_REGS   = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  SCL,
    inout  wire                   SDA,
    output logic [NUM_REGS*8-1:0] regs,
    output logic                  done,
    input  logic                  done_ack,
    output logic                  busy
);
    localparam int PW = $clog2(NUM_REGS);

    typedef enum logic [2:0] {IDLE, ADDR, ADDR_ACK, PTR, ACK_W, WDATA, RDATA, RACK} state_t;

    state_t          state_q, state_d;
    logic [1:0]      scl_sync_q, scl_sync_d, sda_sync_q, sda_sync_d;
    logic            scl_prev_q, scl_prev_d, sda_prev_q, sda_prev_d;
    logic [3:0]      bit_cnt_q, bit_cnt_d;
    logic [7:0]      rx_q, rx_d;
    logic [6:0]      tx_q, tx_d;
    logic [PW-1:0]   ptr_q, ptr_d, ptr_inc;
    logic [7:0]      wcnt_q, wcnt_d;
    logic            sda_oe_q, sda_oe_d, busy_q, busy_d, done_q, done_d;
    logic [7:0]      regs_q [NUM_REGS];
    logic [7:0]      regs_d [NUM_REGS];
    logic            scl_s, sda_s, scl_rise, scl_fall, start, stop;

    assign scl_s    = scl_sync_q[1];
    assign sda_s    = sda_sync_q[1];
    assign scl_rise = scl_s & ~scl_prev_q;
    assign scl_fall = ~scl_s & scl_prev_q;
    assign start    = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
    assign stop     = scl_s & scl_prev_q & ~sda_prev_q & sda_s;
    assign ptr_inc  = (ptr_q == PW'(NUM_REGS - 1)) ? '0 : ptr_q + 1'b1;

    assign SDA  = sda_oe_q ? 1'b0 : 1'bz;
    assign done = done_q;
    assign busy = busy_q;

    for (genvar k = 0; k < NUM_REGS; k++) begin : g_flat
        assign regs[8*k +: 8] = regs_q[k];
    end

    // Bus event decode and protocol FSM; START/STOP override whatever byte phase is in progress
    always_comb begin
        scl_sync_d = {scl_sync_q[0], SCL};
        sda_sync_d = {sda_sync_q[0], SDA};
        scl_prev_d = scl_s;
        sda_prev_d = sda_s;
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        rx_d       = rx_q;
        tx_d       = tx_q;
        ptr_d      = ptr_q;
        wcnt_d     = wcnt_q;
        sda_oe_d   = sda_oe_q;
        busy_d     = busy_q;
        regs_d     = regs_q;
        done_d     = done_q & ~done_ack;
        if (start) begin
            state_d   = ADDR;
            bit_cnt_d = '0;
            sda_oe_d  = 1'b0;
            busy_d    = 1'b0;
        end else if (stop) begin
            state_d  = IDLE;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
            wcnt_d   = '0;
            done_d   = done_d | (wcnt_q != 8'd0);
        end else begin
            if (scl_rise && (state_q == ADDR || state_q == PTR || state_q == WDATA || state_q == RDATA)) begin
                bit_cnt_d = bit_cnt_q + 4'd1;
                rx_d      = {rx_q[6:0], sda_s};
            end
            case (state_q)
                ADDR: if (scl_fall && bit_cnt_q == 4'd8) begin
                    if (rx_q[7:1] == SLAVE_ADDR && !done_q) begin
                        sda_oe_d = 1'b1;
                        busy_d   = 1'b1;
                        state_d  = ADDR_ACK;
                    end else begin
                        state_d = IDLE;
                    end
                end
                ADDR_ACK: if (scl_fall) begin
                    bit_cnt_d = '0;
                    state_d   = rx_q[0] ? RDATA : PTR;
                    tx_d      = regs_q[ptr_q][6:0];
                    sda_oe_d  = rx_q[0] & ~regs_q[ptr_q][7];
                end
                PTR: if (scl_fall && bit_cnt_q == 4'd8) begin
                    if (rx_q < 8'(NUM_REGS)) begin
                        ptr_d    = rx_q[PW-1:0];
                        sda_oe_d = 1'b1;
                        state_d  = ACK_W;
                    end else begin
                        state_d = IDLE;
                    end
                end
                ACK_W: if (scl_fall) begin
                    sda_oe_d  = 1'b0;
                    bit_cnt_d = '0;
                    state_d   = WDATA;
                end
                WDATA: if (scl_fall && bit_cnt_q == 4'd8) begin
                    regs_d[ptr_q] = rx_q;
                    ptr_d         = ptr_inc;
                    wcnt_d        = (wcnt_q == 8'hFF) ? wcnt_q : wcnt_q + 8'd1;
                    sda_oe_d      = 1'b1;
                    state_d       = ACK_W;
                end
                RDATA: if (scl_fall) begin
                    if (bit_cnt_q == 4'd8) begin
                        sda_oe_d = 1'b0;
                        state_d  = RACK;
                    end else begin
                        tx_d     = {tx_q[5:0], 1'b0};
                        sda_oe_d = ~tx_q[6];
                    end
                end
                RACK: begin
                    if (scl_rise) begin
                        state_d = sda_s ? IDLE : RACK;
                        ptr_d   = sda_s ? ptr_q : ptr_inc;
                    end
                    if (scl_fall) begin
                        bit_cnt_d = '0;
                        state_d   = RDATA;
                        tx_d      = regs_q[ptr_q][6:0];
                        sda_oe_d  = ~regs_q[ptr_q][7];
                    end
                end
                default: ;
            endcase
        end
    end

    // State registers; reset releases SDA immediately and clears the register file
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            scl_sync_q <= 2'b11;
            sda_sync_q <= 2'b11;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
            bit_cnt_q  <= '0;
            rx_q       <= '0;
            tx_q       <= '0;
            ptr_q      <= '0;
            wcnt_q     <= '0;
            sda_oe_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            regs_q     <= '{default: '0};
        end else begin
            state_q    <= state_d;
            scl_sync_q <= scl_sync_d;
            sda_sync_q <= sda_sync_d;
            scl_prev_q <= scl_prev_d;
            sda_prev_q <= sda_prev_d;
            bit_cnt_q  <= bit_cnt_d;
            rx_q       <= rx_d;
            tx_q       <= tx_d;
            ptr_q      <= ptr_d;
            wcnt_q     <= wcnt_d;
            sda_oe_q   <= sda_oe_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            regs_q     <= regs_d;
        end
    end
endmodule

// File: tb/tb_i2c_regfile_slave.sv
// tb_i2c_regfile_slave: directed I2C controller transactions against the register-file target
module tb_i2c_regfile_slave;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        scl = 1'b1;
    logic        sda_low = 1'b0;
    logic        done_ack = 1'b0;
    wire         sda;
    logic [63:0] regs;
    logic        done, busy;
    int          n_checks = 0;
    int          n_errors = 0;
    int          low_cnt = 0;

    assign sda = sda_low ? 1'b0 : 1'bz;
    pullup (sda);

    i2c_regfile_slave #(.SLAVE_ADDR(7'h55), .NUM_REGS(8)) dut (
        .clk(clk), .reset(reset), .SCL(scl), .SDA(sda),
        .regs(regs), .done(done), .done_ack(done_ack), .busy(busy)
    );

    always #5 clk = ~clk;

    // Count clocks where the target pulls SDA low while the controller has released it
    always @(posedge clk) if (!sda_low && sda === 1'b0) low_cnt <= low_cnt + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic bit_out(input logic b);
        sda_low = ~b; #60; scl = 1'b1; #100; scl = 1'b0; #60;
    endtask

    task automatic bit_in(output logic b);
        sda_low = 1'b0; #60; scl = 1'b1; #50; b = sda; #50; scl = 1'b0; #60;
    endtask

    task automatic byte_out(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) bit_out(d[i]);
        bit_in(ack);
    endtask

    task automatic byte_in(output logic [7:0] d, input logic nack);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            bit_in(b);
            d[i] = b;
        end
        bit_out(nack);
    endtask

    task automatic bus_start;
        sda_low = 1'b1; #60; scl = 1'b0; #60;
    endtask

    task automatic bus_rstart;
        sda_low = 1'b0; #60; scl = 1'b1; #60; sda_low = 1'b1; #60; scl = 1'b0; #60;
    endtask

    task automatic bus_stop;
        sda_low = 1'b1; #60; scl = 1'b1; #60; sda_low = 1'b0; #100;
    endtask

    task automatic pulse_ack;
        done_ack = 1'b1; #10; done_ack = 1'b0; #10;
    endtask

    initial begin
        logic       ack;
        logic [7:0] d;
        int         c0;
        #40 reset = 1'b0;
        #60;
        check("reset_regs", regs, 64'h0);
        check("reset_done", done, 1'b0);
        check("reset_busy", busy, 1'b0);
        check("reset_sda", sda, 1'b1);

        // Write burst at pointer 2
        bus_start;
        byte_out(8'hAA, ack); check("wb_addr_ack", ack, 1'b0);
        check("wb_busy", busy, 1'b1);
        byte_out(8'h02, ack); check("wb_ptr_ack", ack, 1'b0);
        byte_out(8'h11, ack); check("wb_d0_ack", ack, 1'b0);
        byte_out(8'h22, ack); check("wb_d1_ack", ack, 1'b0);
        byte_out(8'h33, ack); check("wb_d2_ack", ack, 1'b0);
        bus_stop;
        check("wb_regs", regs, 64'h00000033_22110000);
        check("wb_done", done, 1'b1);
        check("wb_busy_off", busy, 1'b0);
        pulse_ack;
        check("wb_done_clr", done, 1'b0);

        // Pointer wrap on write
        bus_start;
        byte_out(8'hAA, ack); check("wr_addr_ack", ack, 1'b0);
        byte_out(8'h07, ack); check("wr_ptr_ack", ack, 1'b0);
        byte_out(8'hA0, ack); check("wr_d0_ack", ack, 1'b0);
        byte_out(8'hA1, ack); check("wr_d1_ack", ack, 1'b0);
        bus_stop;
        check("wr_regs", regs, 64'hA0000033_221100A1);
        check("wr_done", done, 1'b1);
        pulse_ack;

        // Read back across the wrap via repeated START
        bus_start;
        byte_out(8'hAA, ack); check("rd_addr_ack", ack, 1'b0);
        byte_out(8'h07, ack); check("rd_ptr_ack", ack, 1'b0);
        bus_rstart;
        byte_out(8'hAB, ack); check("rd_raddr_ack", ack, 1'b0);
        byte_in(d, 1'b0); check("rd_byte0", d, 8'hA0);
        byte_in(d, 1'b1); check("rd_byte1", d, 8'hA1);
        bus_stop;
        check("rd_done", done, 1'b0);
        check("rd_regs", regs, 64'hA0000033_221100A1);

        // Wrong address: target must never pull SDA
        c0 = low_cnt;
        bus_start;
        byte_out(8'hA8, ack); check("na_ack", ack, 1'b1);
        check("na_sda_drive", low_cnt - c0, 0);
        check("na_busy", busy, 1'b0);
        bus_stop;

        // Out-of-range pointer
        bus_start;
        byte_out(8'hAA, ack); check("np_addr_ack", ack, 1'b0);
        byte_out(8'h08, ack); check("np_ptr_nack", ack, 1'b1);
        bus_stop;
        check("np_regs", regs, 64'hA0000033_221100A1);
        check("np_done", done, 1'b0);

        // Busy NACK while done is pending
        bus_start;
        byte_out(8'hAA, ack);
        byte_out(8'h01, ack);
        byte_out(8'h5C, ack); check("bz_d_ack", ack, 1'b0);
        bus_stop;
        check("bz_done", done, 1'b1);
        bus_start;
        byte_out(8'hAA, ack); check("bz_addr_nack", ack, 1'b1);
        bus_stop;
        check("bz_regs", regs, 64'hA0000033_22115CA1);
        check("bz_done_held", done, 1'b1);
        pulse_ack;
        check("bz_done_clr", done, 1'b0);
        bus_start;
        byte_out(8'hAA, ack); check("bz_addr_ack", ack, 1'b0);
        byte_out(8'h01, ack);
        byte_out(8'h77, ack); check("bz_d2_ack", ack, 1'b0);
        bus_stop;
        check("bz_regs2", regs, 64'hA0000033_221177A1);
        pulse_ack;

        // STOP after 4 data bits
        bus_start;
        byte_out(8'hAA, ack);
        byte_out(8'h05, ack); check("ab_ptr_ack", ack, 1'b0);
        bit_out(1'b1); bit_out(1'b0); bit_out(1'b1); bit_out(1'b0);
        bus_stop;
        check("ab_regs", regs, 64'hA0000033_221177A1);
        check("ab_done", done, 1'b0);

        // done_ack in the same clock STOP is detected
        bus_start;
        byte_out(8'hAA, ack);
        byte_out(8'h06, ack);
        byte_out(8'h66, ack); check("co_d_ack", ack, 1'b0);
        sda_low = 1'b1; #60; scl = 1'b1; #60; sda_low = 1'b0;
        #20 done_ack = 1'b1;
        #10 done_ack = 1'b0;
        #70;
        check("co_done", done, 1'b1);
        check("co_regs", regs, 64'hA0660033_221177A1);
        pulse_ack;

        // Reset mid-read while target drives a 0 bit (reg1 = 0x77, MSB 0)
        bus_start;
        byte_out(8'hAA, ack);
        byte_out(8'h01, ack);
        bus_rstart;
        byte_out(8'hAB, ack); check("rs_addr_ack", ack, 1'b0);
        check("rs_sda_low", sda, 1'b0);
        reset = 1'b1;
        #1;
        check("rs_sda_rel", sda, 1'b1);
        check("rs_regs", regs, 64'h0);
        check("rs_busy", busy, 1'b0);
        check("rs_done", done, 1'b0);
        #9 reset = 1'b0;
        scl = 1'b1;
        #100;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/i2c_regfile_slave.md
# i2c_regfile_slave

Parametrised I2C target that exposes a register file of `NUM_REGS` bytes to an external I2C controller over SCL/SDA. It is the successor to the fixed five-register write-only slave.
- Adds a register pointer byte, auto-increment with wrap, controller reads, repeated START, and START/STOP detection in every state.
- Adds a NACK-while-busy handshake toward the local consumer.
- Sits between the board I2C pins and the video-processing control logic, which reads `regs` and acknowledges `done`.

## Interface
- `SLAVE_ADDR`, 7'h55, 7-bit target address matched against the first byte after START.
- `NUM_REGS`, 8, number of 8-bit registers; range 2..128. Pointer width `PW = $clog2(NUM_REGS)`.
- `clk` input 1 — system clock; all logic is on its rising edge.
- `reset` input 1 — asynchronous, active-high reset.
- `SCL` input 1 — I2C clock from the controller.
- `SDA` inout 1 — I2C data; open-drain: driven 0 or left at `'z`, never driven 1.
- `regs` output NUM_REGS*8 — flattened register file; reg k occupies bits [8k+7:8k].
- `done` output 1 — set at the STOP of a write transaction that wrote at least one data byte; held until `done_ack`.
- `done_ack` input 1 — consumer acknowledge; clears `done` on the cycle it is sampled high.
- `busy` output 1 — high from the START with an address match until the following STOP or START.

## Operation
- **Synchronisation:** SCL and SDA each pass through a 2-flop synchroniser (reset value 1).
- **Bus events:** all decoding uses the synced signals `scl_s` and `sda_s`.
  - START = `sda_s` falls while `scl_s` is high.
  - STOP = `sda_s` rises while `scl_s` is high.
  - Data is sampled on the `scl_s` rising edge.
  - SDA drive changes only on the `scl_s` falling edge.
- **Event priority:** START and STOP are recognised in every state and override the current state. START → ADDR with bit counter cleared. STOP → IDLE, with `done` set if the write-byte count is ≥1.
- **States and transitions:**
  - IDLE: wait for START.
  - ADDR: shift 8 bits, MSB first.
  - ADDR_ACK, entered after the 8th falling edge:
    - ACK (drive SDA low for one SCL period) if addr[7:1]==SLAVE_ADDR and `done`==0; otherwise release SDA and go to IDLE.
    - After ACK, R/W=0 → PTR; R/W=1 → RDATA.
  - PTR: receive 8 bits.
    - Value < NUM_REGS: ACK, load `ptr`, go to WDATA.
    - Otherwise: NACK, go to IDLE, `ptr` unchanged.
  - WDATA: receive byte; at the 8th falling edge write `regs[ptr]`, ACK, then ptr ← (ptr==NUM_REGS-1) ? 0 : ptr+1, and increment the write-byte count (saturating).
  - RDATA: drive `regs[ptr]` MSB first. Each bit is placed after an SCL falling edge; SDA released for 1-bits.
  - RACK: release SDA and sample the controller ACK on the SCL rising edge.
    - ACK (0): increment `ptr` with wrap, go to RDATA.
    - NACK (1): go to IDLE, then await STOP or START.
- **Repeated START:** PTR followed by START and a read address reads from the just-loaded pointer.
- **Done handshake:**
  - `done` clears on `done_ack`.
  - If STOP and `done_ack` coincide, `done` stays 1 (the new event wins).
  - While `done`=1 the address is NACKed, so the consumer never sees `regs` change under it.
- **Read data:** a read returns the current `regs` contents; no side effects.
- **Reset:** mid-transfer reset returns to IDLE immediately, releases SDA, and clears `regs`, `ptr`, counters, `done` and `busy`.

## Timing
- **Reset values:** `regs`=0, `done`=0, `busy`=0, SDA released (`'z`), `ptr`=0, state IDLE.
- **Input latency:** a pin edge is visible internally 2 clk later; the edge pulse fires 3 clk after the pin edge.
- **Clock ratio:** SCL high and low phases must each be ≥4 clk; hold of SDA after SCL falls must be ≥3 clk. Example: 100 MHz clk supports SCL ≤ 400 kHz.
- **SDA drive:** ACK drive and read-bit drive update within 1 clk of the detected SCL falling edge. Drive is released within 1 clk of the falling edge that ends the ACK/bit slot.
- **Register write:** `regs` byte updates 1 clk after the 8th detected SCL falling edge of a WDATA byte.
- **`done`:** rises 1 clk after STOP is detected.
- **`busy`:** rises 1 clk after the address ACK decision.

## Test plan
- **Write burst:** START, 0xAA (0x55 write), ptr 0x02, data 0x11 0x22 0x33, STOP → all bytes ACKed; reg2=0x11, reg3=0x22, reg4=0x33; `done`=1 until `done_ack`, then 0.
- **Wrap and read-back:** write ptr 0x07, data 0xA0 0xA1 (NUM_REGS=8) → reg7=0xA0, reg0=0xA1. Then START, 0xAA, ptr 0x07, repeated START, 0xAB, controller ACK, NACK → read bytes 0xA0, 0xA1.
- **Address and pointer rejection:**
  - Address 0xA8 (0x54) → SDA never driven, state IDLE.
  - Ptr 0x08 → NACK, all `regs` unchanged.
- **Busy NACK:** with `done`=1 and no ack, address 0xAA → NACK, `regs` unchanged. After `done_ack` the same transfer is ACKed.
- **Aborted byte:** STOP after 4 data bits → no register written, `done` stays 0 if no full byte was written. Assert `reset` mid-RDATA while SDA is low → SDA released in the same cycle and `regs`=0.
- **Event collision:** `done_ack` asserted in the same clk that STOP is detected → `done`=1 afterwards.
